// File: rtl/ks0108_bus_ctrl.sv
// ks0108_bus_ctrl: write-only KS0108 panel bus sequencer.
// Generates the panel reset pulse and setup/E/hold timing per byte.
module ks0108_bus_ctrl #(
    parameter int RESET_CYCLES     = 16,
    parameter int INIT_WAIT_CYCLES = 32,
    parameter int SETUP_CYCLES     = 2,
    parameter int E_HIGH_CYCLES    = 8,
    parameter int HOLD_CYCLES      = 1,
    parameter int RECOVER_CYCLES   = 8
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_dc,
    input  logic [1:0] cmd_cs,
    input  logic [7:0] cmd_data,
    output logic       busy,
    output logic       ks_dc,
    output logic       ks_cs1,
    output logic       ks_cs2,
    output logic       ks_e,
    output logic       ks_reset,
    output logic [7:0] ks_data
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAXP = max2(max2(max2(RESET_CYCLES, INIT_WAIT_CYCLES),
                                    max2(SETUP_CYCLES, E_HIGH_CYCLES)),
                               max2(HOLD_CYCLES, RECOVER_CYCLES));
    localparam int CW = $clog2(MAXP) + 1;

    // Each state is left on the edge where the counter reads zero,
    // so the load value is the state length minus one.
    localparam logic [CW-1:0] L_RST  = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] L_INIT = CW'(INIT_WAIT_CYCLES - 1);
    localparam logic [CW-1:0] L_SET  = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] L_EH   = CW'(E_HIGH_CYCLES - 1);
    localparam logic [CW-1:0] L_HOLD = CW'(HOLD_CYCLES - 1);
    // The last recover cycle is spent in IDLE with cmd_ready high, so a
    // held request is accepted exactly RECOVER_CYCLES after hold ends.
    localparam int REC_N = (RECOVER_CYCLES > 1) ? RECOVER_CYCLES - 2 : 0;
    localparam logic [CW-1:0] L_REC  = CW'(REC_N);
    localparam bit REC_SHORT = (RECOVER_CYCLES == 1);

    typedef enum logic [2:0] {
        RST_PULSE,
        INIT_WAIT,
        IDLE,
        SETUP,
        E_HIGH,
        HOLD,
        RECOVER
    } state_t;

    state_t          r_state, w_state;
    logic [CW-1:0]   r_cnt, w_cnt;
    logic            r_ready, w_ready;
    logic            r_busy, w_busy;
    logic            r_dc, w_dc;
    logic            r_cs1, w_cs1;
    logic            r_cs2, w_cs2;
    logic            r_e, w_e;
    logic            r_rst, w_rst;
    logic [7:0]      r_data, w_data;
    logic            w_zero;

    assign w_zero = (r_cnt == '0);

    // Next-state, counter and registered-output computation.
    always_comb begin
        w_state = r_state;
        w_cnt   = w_zero ? r_cnt : r_cnt - 1'b1;
        w_ready = r_ready;
        w_busy  = r_busy;
        w_dc    = r_dc;
        w_cs1   = r_cs1;
        w_cs2   = r_cs2;
        w_e     = r_e;
        w_rst   = r_rst;
        w_data  = r_data;
        unique case (r_state)
            RST_PULSE: begin
                if (w_zero) begin
                    w_rst   = 1'b1;
                    w_cnt   = L_INIT;
                    w_state = INIT_WAIT;
                end
            end
            INIT_WAIT: begin
                if (w_zero) begin
                    w_ready = 1'b1;
                    w_busy  = 1'b0;
                    w_state = IDLE;
                end
            end
            IDLE: begin
                if (cmd_valid && r_ready) begin
                    w_dc    = cmd_dc;
                    w_cs1   = cmd_cs[0];
                    w_cs2   = cmd_cs[1];
                    w_data  = cmd_data;
                    w_ready = 1'b0;
                    w_busy  = 1'b1;
                    w_cnt   = L_SET;
                    w_state = SETUP;
                end
            end
            SETUP: begin
                if (w_zero) begin
                    w_e     = 1'b1;
                    w_cnt   = L_EH;
                    w_state = E_HIGH;
                end
            end
            E_HIGH: begin
                if (w_zero) begin
                    w_e     = 1'b0;
                    w_cnt   = L_HOLD;
                    w_state = HOLD;
                end
            end
            HOLD: begin
                if (w_zero) begin
                    w_cs1 = 1'b0;
                    w_cs2 = 1'b0;
                    if (REC_SHORT) begin
                        w_ready = 1'b1;
                        w_busy  = 1'b0;
                        w_state = IDLE;
                    end else begin
                        w_cnt   = L_REC;
                        w_state = RECOVER;
                    end
                end
            end
            RECOVER: begin
                if (w_zero) begin
                    w_ready = 1'b1;
                    w_busy  = 1'b0;
                    w_state = IDLE;
                end
            end
            default: begin
                w_cnt   = L_RST;
                w_state = RST_PULSE;
            end
        endcase
    end

    // State, counter and output registers; reset restarts the panel pulse.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= RST_PULSE;
            r_cnt   <= L_RST;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_dc    <= 1'b0;
            r_cs1   <= 1'b0;
            r_cs2   <= 1'b0;
            r_e     <= 1'b0;
            r_rst   <= 1'b0;
            r_data  <= 8'h00;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_ready <= w_ready;
            r_busy  <= w_busy;
            r_dc    <= w_dc;
            r_cs1   <= w_cs1;
            r_cs2   <= w_cs2;
            r_e     <= w_e;
            r_rst   <= w_rst;
            r_data  <= w_data;
        end
    end

    assign cmd_ready = r_ready;
    assign busy      = r_busy;
    assign ks_dc     = r_dc;
    assign ks_cs1    = r_cs1;
    assign ks_cs2    = r_cs2;
    assign ks_e      = r_e;
    assign ks_reset  = r_rst;
    assign ks_data   = r_data;

endmodule

// File: tb/tb_ks0108_bus_ctrl.sv
// tb_ks0108_bus_ctrl: directed bench for ks0108_bus_ctrl.
// Edge numbers are counted from the handshake edge T.
module tb_ks0108_bus_ctrl;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_dc = 1'b0;
    logic [1:0] cmd_cs = 2'b00;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_ready, busy;
    logic       ks_dc, ks_cs1, ks_cs2, ks_e, ks_reset;
    logic [7:0] ks_data;

    int n_chk = 0;
    int n_fail = 0;

    ks0108_bus_ctrl dut (
        .clk      (clk),
        .nreset   (nreset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_dc   (cmd_dc),
        .cmd_cs   (cmd_cs),
        .cmd_data (cmd_data),
        .busy     (busy),
        .ks_dc    (ks_dc),
        .ks_cs1   (ks_cs1),
        .ks_cs2   (ks_cs2),
        .ks_e     (ks_e),
        .ks_reset (ks_reset),
        .ks_data  (ks_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        check({tag, "_rst"},  ks_reset, 0);
        check({tag, "_e"},    ks_e, 0);
        check({tag, "_cs1"},  ks_cs1, 0);
        check({tag, "_cs2"},  ks_cs2, 0);
        check({tag, "_dc"},   ks_dc, 0);
        check({tag, "_data"}, ks_data, 8'h00);
        check({tag, "_rdy"},  cmd_ready, 0);
        check({tag, "_busy"}, busy, 1);
    endtask

    // Reset low for 5 cycles, then walk edges 1..48 of the power-up.
    task automatic powerup();
        nreset = 1'b0;
        cmd_valid = 1'b0;
        repeat (5) tick();
        chk_reset_vals("in_rst");
        nreset = 1'b1;
        for (int k = 1; k <= 48; k++) begin
            tick();
            check("pu_ksrst", ks_reset, k >= 16);
            check("pu_rdy", cmd_ready, k >= 48);
            check("pu_busy", busy, k < 48);
            check("pu_e", ks_e, 0);
        end
    endtask

    // One transfer from IDLE; optionally pulses a second request mid-E.
    task automatic xfer(input logic dc, input logic [1:0] cs,
                        input logic [7:0] d, input bit ign);
        logic e_exp, r_exp;
        check("x_idle_rdy", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_dc = dc;
        cmd_cs = cs;
        cmd_data = d;
        tick();
        cmd_valid = 1'b0;
        cmd_dc = ~dc;
        cmd_cs = ~cs;
        cmd_data = ~d;
        for (int i = 0; i <= 19; i++) begin
            if (i > 0) tick();
            if (ign && i == 4) begin
                cmd_valid = 1'b1;
                cmd_data = 8'h55;
                cmd_cs = 2'b11;
            end
            if (ign && i == 5) cmd_valid = 1'b0;
            e_exp = (i >= 2) && (i < 10);
            r_exp = (i >= 18);
            check("x_data", ks_data, d);
            check("x_dc", ks_dc, dc);
            check("x_cs1", ks_cs1, (i < 11) ? cs[0] : 1'b0);
            check("x_cs2", ks_cs2, (i < 11) ? cs[1] : 1'b0);
            check("x_e", ks_e, e_exp);
            check("x_rdy", cmd_ready, r_exp);
            check("x_busy", busy, !r_exp);
        end
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        while (!cmd_ready && n < budget) begin
            tick();
            n++;
        end
        check("wait_rdy", cmd_ready, 1);
    endtask

    initial begin
        logic e_exp;
        powerup();

        // Single write: dc=1, cs=01, data=A5.
        xfer(1'b1, 2'b01, 8'hA5, 1'b0);
        repeat (2) tick();

        // Back-to-back: 3F (dc=0, cs=11) then C0 (dc=1, cs=01).
        cmd_valid = 1'b1;
        cmd_dc = 1'b0;
        cmd_cs = 2'b11;
        cmd_data = 8'h3F;
        tick();
        cmd_dc = 1'b1;
        cmd_cs = 2'b01;
        cmd_data = 8'hC0;
        for (int i = 1; i <= 21; i++) begin
            tick();
            e_exp = ((i >= 2) && (i < 10)) || (i >= 21);
            check("bb_data", ks_data, (i < 19) ? 8'h3F : 8'hC0);
            check("bb_dc", ks_dc, i >= 19);
            check("bb_cs1", ks_cs1, (i < 11) || (i >= 19));
            check("bb_cs2", ks_cs2, i < 11);
            check("bb_e", ks_e, e_exp);
            check("bb_rdy", cmd_ready, i == 18);
            if (i == 19) cmd_valid = 1'b0;
        end
        wait_ready(40);
        check("bb_end_data", ks_data, 8'hC0);

        // Request during E_HIGH of an AA transfer is ignored.
        xfer(1'b0, 2'b10, 8'hAA, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ign_data", ks_data, 8'hAA);
            check("ign_rdy", cmd_ready, 1);
            check("ign_e", ks_e, 0);
        end

        // Null select still pulses E with both selects low.
        xfer(1'b1, 2'b00, 8'h12, 1'b0);
        tick();

        // Reset asserted while E is high.
        cmd_valid = 1'b1;
        cmd_dc = 1'b1;
        cmd_cs = 2'b01;
        cmd_data = 8'h77;
        tick();
        cmd_valid = 1'b0;
        repeat (4) tick();
        check("mid_e_pre", ks_e, 1);
        check("mid_data_pre", ks_data, 8'h77);
        #2;
        nreset = 1'b0;
        #1;
        chk_reset_vals("mid");
        powerup();

        // Normal operation resumes after the repeated power-up.
        xfer(1'b1, 2'b11, 8'h3C, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
